// File: rtl/mem_access_unit.sv
// Purpose : load/store sequencer between the ALU/register-file stage and a 64-bit synchronous data RAM.
// Latency : resp_valid in cycle 3 for loads, cycle 2 for doubleword stores, cycle 4 for sub-word stores.
// Backpres: req_ready is high only in IDLE; a request offered while busy is held by the master until accepted.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake; is_store, size, sign_ext, addr, wdata qualify it
//   resp_valid, rdata, err        one-cycle completion pulse with load result and misalignment flag
//   ram_address, ram_read_en,     word-indexed RAM interface; ram_out is the RAM's registered read data
//   ram_write_en, ram_data_in, ram_out
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word/doubleword accesses with err = 1.
// Without it, err is tied low and misaligned offsets are rounded down to the containing aligned field.
module mem_access_unit #(
    parameter int WORD_IDX_W = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        resp_valid,
    output logic [63:0] rdata,
    output logic        err,
    output logic [63:0] ram_address,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [63:0] ram_data_in,
    input  logic [63:0] ram_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;

    // Request fields captured at acceptance.
    logic        lat_store;
    logic [1:0]  lat_size;
    logic        lat_sext;
    logic [2:0]  lat_off;
    logic [63:0] lat_wdata;

    // Word index of the incoming request; upper address bits alias onto the RAM.
    logic [63:0] req_word_idx;
    assign req_word_idx = {{(64 - WORD_IDX_W){1'b0}}, addr[WORD_IDX_W+2:3]};

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[63:WORD_IDX_W+3];

    // Only IDLE accepts; reset forces the output low so every output reads 0 under reset.
    assign req_ready = (state == S_IDLE) && !reset;

    // Byte offset rounded down to the field boundary of the latched size.
    logic [2:0]  eff_off;
    logic [5:0]  shamt;
    logic [63:0] field_mask;
    logic [63:0] shifted;
    logic [63:0] load_val;
    logic [63:0] merged;

    always_comb begin
        eff_off    = lat_off;
        field_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (lat_size)
            2'd0: begin
                eff_off    = lat_off;
                field_mask = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                eff_off    = {lat_off[2:1], 1'b0};
                field_mask = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                eff_off    = {lat_off[2], 2'b00};
                field_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                eff_off    = 3'd0;
                field_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
        shamt   = {eff_off, 3'b000};
        shifted = ram_out >> shamt;

        case (lat_size)
            2'd0:    load_val = lat_sext ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
            2'd1:    load_val = lat_sext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            2'd2:    load_val = lat_sext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default: load_val = ram_out;
        endcase

        // Read-modify-write: clear the target lanes, then drop in the low field bits of wdata.
        merged = (ram_out & ~(field_mask << shamt)) | ((lat_wdata & field_mask) << shamt);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        case (size)
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            2'd3:    misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lat_store    <= 1'b0;
            lat_size     <= 2'd0;
            lat_sext     <= 1'b0;
            lat_off      <= 3'd0;
            lat_wdata    <= 64'd0;
            resp_valid   <= 1'b0;
            rdata        <= 64'd0;
            ram_address  <= 64'd0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            ram_data_in  <= 64'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            err_q        <= 1'b0;
`endif
        end else begin
            // Pulses and enables default low; the state that needs them raises them for one cycle.
            resp_valid   <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            err_q        <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_store   <= is_store;
                        lat_size    <= size;
                        lat_sext    <= sign_ext;
                        lat_off     <= addr[2:0];
                        lat_wdata   <= wdata;
                        ram_address <= req_word_idx;
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            rdata      <= 64'd0;
                            err_q      <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else
`endif
                        if (is_store && size == 2'd3) begin
                            // Full-word store needs no read; write straight away.
                            ram_data_in  <= wdata;
                            ram_write_en <= 1'b1;
                            state        <= S_WRITE;
                        end else begin
                            ram_read_en <= 1'b1;
                            state       <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // RAM registers its output on this edge; data is on ram_out in CAPTURE.
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (lat_store) begin
                        ram_data_in  <= merged;
                        ram_write_en <= 1'b1;
                        state        <= S_WRITE;
                    end else begin
                        rdata      <= load_val;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        resp_valid;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] ram_address;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [63:0] ram_data_in;
    logic [63:0] ram_out;

    int checks;
    int failures;

    mem_access_unit #(.WORD_IDX_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .is_store     (is_store),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .resp_valid   (resp_valid),
        .rdata        (rdata),
        .err          (err),
        .ram_address  (ram_address),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_data_in  (ram_data_in),
        .ram_out      (ram_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 32 x 64 synchronous RAM with registered read data.
    logic [63:0] mem [0:31];
    always @(posedge clock) begin
        if (ram_read_en)  ram_out <= mem[ram_address[4:0]];
        if (ram_write_en) mem[ram_address[4:0]] <= ram_data_in;
    end

    // Advance one cycle; sample point is the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_req(input logic st, input logic [1:0] sz, input logic sx,
                             input logic [63:0] a, input logic [63:0] wd);
        req_valid = 1'b1;
        is_store  = st;
        size      = sz;
        sign_ext  = sx;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        @(negedge clock);
        checks++; if ({resp_valid, err, ram_read_en, ram_write_en} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {resp_valid, err, ram_read_en, ram_write_en}); end
        checks++; if ({rdata, ram_address, ram_data_in} !== 192'd0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", rdata, ram_address, ram_data_in); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
        @(negedge clock);
    endtask

    task automatic test_dword_store();
        drive_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211);
        step(); req_valid = 1'b0;
        checks++; if ({ram_write_en, ram_read_en} !== 2'b10) begin failures++; $display("FAIL t1_c1_en got=%b exp=10", {ram_write_en, ram_read_en}); end
        checks++; if (ram_address !== 64'd2) begin failures++; $display("FAIL t1_c1_addr got=%h exp=2", ram_address); end
        checks++; if (ram_data_in !== 64'h8877665544332211) begin failures++; $display("FAIL t1_c1_wdata got=%h exp=8877665544332211", ram_data_in); end
        step();
        checks++; if ({resp_valid, err, ram_write_en} !== 3'b100) begin failures++; $display("FAIL t1_c2_resp got=%b exp=100", {resp_valid, err, ram_write_en}); end
        step();
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL t1_c3_idle got=%b exp=01", {resp_valid, req_ready}); end
    endtask

    task automatic test_byte_load();
        drive_req(1'b0, 2'd0, 1'b1, 64'h17, 64'd0);
        step(); req_valid = 1'b0;
        checks++; if ({ram_read_en, ram_write_en} !== 2'b10 || ram_address !== 64'd2) begin failures++; $display("FAIL t2_c1_read got=%b/%h exp=10/2", {ram_read_en, ram_write_en}, ram_address); end
        step();
        checks++; if ({ram_read_en, resp_valid} !== 2'b00) begin failures++; $display("FAIL t2_c2_quiet got=%b exp=00", {ram_read_en, resp_valid}); end
        step();
        checks++; if (resp_valid !== 1'b1 || rdata !== 64'hFFFFFFFFFFFFFF88) begin failures++; $display("FAIL t2_sext got=%b/%h exp=1/ffffffffffffff88", resp_valid, rdata); end
        step();
        checks++; if (resp_valid !== 1'b0 || rdata !== 64'hFFFFFFFFFFFFFF88) begin failures++; $display("FAIL t2_hold got=%b/%h exp=0/ffffffffffffff88", resp_valid, rdata); end
        drive_req(1'b0, 2'd0, 1'b0, 64'h17, 64'd0);
        step(); req_valid = 1'b0;
        step(); step();
        checks++; if (resp_valid !== 1'b1 || rdata !== 64'h0000000000000088) begin failures++; $display("FAIL t2_zext got=%b/%h exp=1/0000000000000088", resp_valid, rdata); end
        step();
    endtask

    task automatic test_half_store();
        drive_req(1'b1, 2'd1, 1'b0, 64'h12, 64'h12345678_9999ABCD);
        step(); req_valid = 1'b0;
        checks++; if ({ram_read_en, ram_write_en} !== 2'b10) begin failures++; $display("FAIL t3_c1_read got=%b exp=10", {ram_read_en, ram_write_en}); end
        step();
        checks++; if ({ram_read_en, ram_write_en, resp_valid} !== 3'b000) begin failures++; $display("FAIL t3_c2_quiet got=%b exp=000", {ram_read_en, ram_write_en, resp_valid}); end
        step();
        checks++; if (ram_write_en !== 1'b1 || ram_data_in !== 64'h88776655ABCD2211) begin failures++; $display("FAIL t3_c3_write got=%b/%h exp=1/88776655abcd2211", ram_write_en, ram_data_in); end
        step();
        checks++; if ({resp_valid, ram_write_en} !== 2'b10) begin failures++; $display("FAIL t3_c4_resp got=%b exp=10", {resp_valid, ram_write_en}); end
        step();
        drive_req(1'b0, 2'd3, 1'b1, 64'h10, 64'd0);
        step(); req_valid = 1'b0;
        step(); step();
        checks++; if (resp_valid !== 1'b1 || rdata !== 64'h88776655ABCD2211) begin failures++; $display("FAIL t3_readback got=%b/%h exp=1/88776655abcd2211", resp_valid, rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 2'd2, 1'b1, 64'h14, 64'd0);
        step();
        checks++; if (req_ready !== 1'b0 || ram_read_en !== 1'b1) begin failures++; $display("FAIL t4_c1 got=%b/%b exp=0/1", req_ready, ram_read_en); end
        step();
        checks++; if (req_ready !== 1'b0 || ram_read_en !== 1'b0) begin failures++; $display("FAIL t4_c2 got=%b/%b exp=0/0", req_ready, ram_read_en); end
        step();
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || rdata !== 64'hFFFFFFFF88776655) begin failures++; $display("FAIL t4_c3 got=%b/%b/%h exp=0/1/ffffffff88776655", req_ready, resp_valid, rdata); end
        step();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL t4_c4_idle got=%b/%b exp=1/0", req_ready, resp_valid); end
        step(); req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || ram_read_en !== 1'b1) begin failures++; $display("FAIL t4_second_accept got=%b/%b exp=0/1", req_ready, ram_read_en); end
        step(); step();
        checks++; if (resp_valid !== 1'b1 || rdata !== 64'hFFFFFFFF88776655) begin failures++; $display("FAIL t4_second_resp got=%b/%h exp=1/ffffffff88776655", resp_valid, rdata); end
        step();
    endtask

    task automatic test_reset_mid_write();
        drive_req(1'b1, 2'd0, 1'b0, 64'h10, 64'h5A);
        step(); req_valid = 1'b0;
        step(); step();
        checks++; if (ram_write_en !== 1'b1) begin failures++; $display("FAIL t5_in_write got=%b exp=1", ram_write_en); end
        reset = 1'b1;
        #1;
        checks++; if ({ram_write_en, ram_read_en, resp_valid, err, req_ready} !== 5'b0) begin failures++; $display("FAIL t5_rst_flags got=%b exp=00000", {ram_write_en, ram_read_en, resp_valid, err, req_ready}); end
        checks++; if ({rdata, ram_address, ram_data_in} !== 192'd0) begin failures++; $display("FAIL t5_rst_data got=%h/%h/%h exp=0", rdata, ram_address, ram_data_in); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL t5_ready_after got=%b exp=1", req_ready); end
        @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL t5_no_resp got=%b exp=0", resp_valid); end
        drive_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
        step(); req_valid = 1'b0;
        step(); step();
        checks++; if (resp_valid !== 1'b1 || rdata !== 64'h88776655ABCD2211) begin failures++; $display("FAIL t5_preserved got=%b/%h exp=1/88776655abcd2211", resp_valid, rdata); end
        step();
    endtask

    task automatic test_misalign();
        drive_req(1'b0, 2'd1, 1'b1, 64'h13, 64'd0);
        step(); req_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if ({resp_valid, err, ram_read_en, ram_write_en} !== 4'b1100) begin failures++; $display("FAIL t6_trap got=%b exp=1100", {resp_valid, err, ram_read_en, ram_write_en}); end
        checks++; if (rdata !== 64'd0) begin failures++; $display("FAIL t6_trap_rdata got=%h exp=0", rdata); end
        step();
        checks++; if ({resp_valid, err, req_ready} !== 3'b001) begin failures++; $display("FAIL t6_trap_after got=%b exp=001", {resp_valid, err, req_ready}); end
`else
        checks++; if ({ram_read_en, resp_valid} !== 2'b10) begin failures++; $display("FAIL t6_read got=%b exp=10", {ram_read_en, resp_valid}); end
        step(); step();
        checks++; if ({resp_valid, err} !== 2'b10 || rdata !== 64'hFFFFFFFFFFFFABCD) begin failures++; $display("FAIL t6_aligned got=%b/%h exp=10/ffffffffffffabcd", {resp_valid, err}, rdata); end
        step();
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        is_store  = 1'b0;
        size      = 2'd0;
        sign_ext  = 1'b0;
        addr      = 64'd0;
        wdata     = 64'd0;
        test_reset();
        test_dword_store();
        test_byte_load();
        test_half_store();
        test_back_to_back();
        test_reset_mid_write();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
